rd73_weight_enum: RTL
=====================

# rd73_weight_enum

Sequential constant-weight word generator: given a weight `k`, it streams every `N`-bit word whose popcount equals `k`, in ascending numeric order, over a valid/ready handshake. It is the inverse of the rd73 popcount functions, which map a 7-bit word to its weight; this block maps a weight back to all words that have it. It sits on the benchmark-verification side of the IWLS NOR flow and drives exhaustive, weight-sorted stimulus into rd73-family netlists.

## Interface
- `N`, default 7: word width; supported range 2..8.
- `W`, default $clog2(N+1) (3 for N=7): width of the weight input.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `weight` in W: requested popcount `k`; sampled together with `start`.
- `abort` in 1: synchronous cancel of a run in progress.
- `busy` out 1: high while in RUN.
- `err` out 1: one-cycle pulse when `start` arrives with `weight > N`.
- `out_valid` out 1: `out_word` holds a valid word.
- `out_ready` in 1: downstream accepts the word.
- `out_word` out N: current word; popcount always equals `k`.
- `out_index` out N: zero-based ordinal of `out_word` within the run.
- `out_last` out 1: high with the final word, ((1<<k)-1)<<(N-k).
- `done` out 1: one-cycle pulse after the last word transfers.

## Operation
- Reset value of every output is 0.
- FSM states are IDLE and RUN.
- IDLE, `start`=1, `weight`≤N: latch `k`, load `out_word`=(1<<k)-1, `out_index`=0, and `out_last`=(k==0 or k==N). Go to RUN with `out_valid`=1 and `busy`=1.
- IDLE, `start`=1, `weight`>N: pulse `err` for one cycle, stay in IDLE. This case is unreachable when N=7.
- RUN, transfer (`out_valid` & `out_ready`) on a non-last word:
  - Compute next = Gosper successor: c = x & -x, r = x + c, next = r | (((r ^ x) >> 2) >> tz(c)).
  - Then `out_index`+1, recompute `out_last`.
  - Do all arithmetic at N+1 bits so the carry out of r is kept; result is truncated to N bits.
- RUN, transfer on the last word: go to IDLE, `out_valid`=0, `busy`=0, `done`=1 for one cycle. `out_word`, `out_index` and `out_last` hold their last values.
- RUN, no transfer: all outputs hold; `out_word` stays stable under backpressure.
- `abort` in RUN (priority over any transfer in the same cycle): go to IDLE. `out_valid`, `busy` and `out_last` drop to 0; no `done` pulse.
- `abort` in IDLE has no effect and is ignored. `start` in the same cycle as `abort` is also ignored.
- `start` in RUN is ignored.
- Word counts per k: C(N,k). For N=7: 1, 7, 21, 35, 35, 21, 7, 1.
- Next-word logic is combinational from registered state. No division; tz is a priority encoder.

## Timing
- `start` sampled at edge t: first word valid from t+1.
- Throughput with `out_ready` held high: one word per cycle.
- With `out_ready` held high, the last transfer is at edge t+C(N,k). `done` is high during the following cycle.
- A new `start` is accepted during the `done` cycle, since the FSM is already in IDLE.
- `rst_n` low at any time: outputs clear immediately (asynchronous). The FSM resumes in IDLE after the first edge following deassertion.

## Test plan
- k=3, ready always 1: 35 words 0x07, 0x0B, 0x0D, 0x0E, 0x13, …, 0x70. `out_last` only on 0x70 (index 34). `done` one cycle later; `busy` low with `done`.
- k=0 and k=7: exactly one word each (0x00, 0x7F), with `out_last`=1 at index 0 and `done` in the next cycle.
- Backpressure, k=2: drop `out_ready` for 5 cycles while 0x05 is valid. `out_word`/`out_index` stay 0x05/1; the next transfer yields 0x06.
- Sweep k=0..7 back to back, restarting each run in the `done` cycle. Scoreboard: every popcount equals k, words strictly ascending, counts match binomials, 128 words in total, no duplicates.
- `abort` at index 10 of k=4, together with `out_ready`=1: no transfer counted, `out_valid`=0 next cycle, no `done`. A following `start` with k=1 gives 0x01.
- `rst_n` pulsed low mid-run, k=5: all outputs 0 asynchronously. `start` ignored while in RUN before the reset. After reset, a `start` with k=5 restarts from 0x1F.

Source files
------------

// File: rtl/rd73_weight_enum.sv
// Constant-weight word generator: streams every N-bit word of popcount k in
// ascending order over a valid/ready handshake (Gosper's successor per step).
module rd73_weight_enum #(
    parameter int N = 7,
    parameter int W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] weight,
    input  logic         abort,
    output logic         busy,
    output logic         err,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_word,
    output logic [N-1:0] out_index,
    output logic         out_last,
    output logic         done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [W:0] N_MAX = (W + 1)'(N);

    state_t       state, state_nx;
    logic [W-1:0] k, k_nx;
    logic [N-1:0] word_nx, index_nx, first, succ;
    logic         last_nx, err_nx, done_nx, bad_weight;
    logic [N:0]   x, c, r, succ_w;
    int           tz;

    // Highest word of weight kk: kk ones packed against the MSB.
    function automatic logic [N-1:0] last_mask(input logic [W-1:0] kk);
        logic [N:0] m;
        m = ((N + 1)'(1) << kk) - (N + 1)'(1);
        m = m << (N - int'(kk));
        return m[N-1:0];
    endfunction

    assign bad_weight = ({1'b0, weight} > N_MAX);
    assign first      = N'(((N + 1)'(1) << weight) - (N + 1)'(1));

    // Gosper successor at N+1 bits so the carry out of r survives the shift.
    assign x = {1'b0, out_word};
    assign c = x & (~x + (N + 1)'(1));
    assign r = x + c;

    always_comb begin
        tz = 0;
        for (int i = N; i >= 0; i--)
            if (c[i]) tz = i;
    end

    assign succ_w = r | (((r ^ x) >> 2) >> tz);
    assign succ   = succ_w[N-1:0];

    assign busy      = (state == RUN);
    assign out_valid = (state == RUN);

    always_comb begin
        state_nx = state;
        k_nx     = k;
        word_nx  = out_word;
        index_nx = out_index;
        last_nx  = out_last;
        err_nx   = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (bad_weight) begin
                        err_nx = 1'b1;
                    end else begin
                        state_nx = RUN;
                        k_nx     = weight;
                        word_nx  = first;
                        index_nx = '0;
                        last_nx  = (first == last_mask(weight));
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                    last_nx  = 1'b0;
                end else if (out_ready) begin
                    if (out_last) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        word_nx  = succ;
                        index_nx = out_index + N'(1);
                        last_nx  = (succ == last_mask(k));
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k         <= '0;
            out_word  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            k         <= k_nx;
            out_word  <= word_nx;
            out_index <= index_nx;
            out_last  <= last_nx;
            err       <= err_nx;
            done      <= done_nx;
        end
    end

endmodule
